// File: rtl/cgra_pkg.sv
// rtl/cgra_pkg.sv - shared CGRA widths, defaults and result-stage state type
package cgra_pkg;
    localparam int DP_WIDTH          = 32;
    localparam int ALU_N_FLAG        = 2;
    localparam int RCS_NUM_CREG_LOG2 = 6;
    localparam int RF_NUM_REG_DEF    = 4;
    localparam int RF_NUM_REG_LOG2   = $clog2(RF_NUM_REG_DEF);
    localparam int MUL_LAT_DEF       = 1;

    typedef enum logic [0:0] {
        EXEC,
        MUL_WAIT
    } rc_res_state_e;
endpackage

// File: rtl/rc_result_stage_if.sv
// rtl/rc_result_stage_if.sv - ALU-to-write-back bundle and registered stage outputs
interface rc_result_stage_if import cgra_pkg::*; #(
    parameter int RF_NUM_REG = RF_NUM_REG_DEF,
    parameter int RF_SEL_W   = $clog2(RF_NUM_REG)
);
    logic                           valid_i;
    logic                           flush_i;
    logic [DP_WIDTH-1:0]            alu_res_i;
    logic [ALU_N_FLAG-1:0]          alu_flag_i;
    logic                           alu_br_req_i;
    logic [RCS_NUM_CREG_LOG2-1:0]   alu_br_add_i;
    logic                           alu_stall_i;
    logic                           flag_we_i;
    logic                           out_we_i;
    logic                           rf_we_i;
    logic [RF_SEL_W-1:0]            rf_wsel_i;
    logic [DP_WIDTH-1:0]            res_o;
    logic [ALU_N_FLAG-1:0]          flag_o;
    logic [RF_NUM_REG*DP_WIDTH-1:0] rf_rdata_o;
    logic                           br_req_o;
    logic [RCS_NUM_CREG_LOG2-1:0]   br_add_o;
    logic                           stall_o;
    logic                           commit_o;

    modport master (
        output valid_i, flush_i, alu_res_i, alu_flag_i, alu_br_req_i, alu_br_add_i,
               alu_stall_i, flag_we_i, out_we_i, rf_we_i, rf_wsel_i,
        input  res_o, flag_o, rf_rdata_o, br_req_o, br_add_o, stall_o, commit_o
    );

    modport slave (
        input  valid_i, flush_i, alu_res_i, alu_flag_i, alu_br_req_i, alu_br_add_i,
               alu_stall_i, flag_we_i, out_we_i, rf_we_i, rf_wsel_i,
        output res_o, flag_o, rf_rdata_o, br_req_o, br_add_o, stall_o, commit_o
    );
endinterface

// File: rtl/rc_rf.sv
// rtl/rc_rf.sv - cell-local register file, single write port, every entry read out flat
module rc_rf #(
    parameter int NUM_REG = 4,
    parameter int WIDTH   = 32,
    parameter int SEL_W   = $clog2(NUM_REG)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [SEL_W-1:0]         wsel_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [NUM_REG*WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] rf_q [NUM_REG];
    logic [WIDTH-1:0] rf_d [NUM_REG];

    // Indices beyond the last entry match nothing, so such writes vanish.
    always_comb begin
        rf_d = rf_q;
        for (int i = 0; i < NUM_REG; i++) begin
            if (we_i && (32'(wsel_i) == i)) begin
                rf_d[i] = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    for (genvar g = 0; g < NUM_REG; g++) begin : g_rd
        assign rdata_o[g*WIDTH +: WIDTH] = rf_q[g];
    end
endmodule

// File: rtl/rc_result_stage.sv
// rtl/rc_result_stage.sv - cell write-back: commits ALU results, flags, branches; sequences multiplies
module rc_result_stage import cgra_pkg::*; #(
    parameter int RF_NUM_REG = RF_NUM_REG_DEF,
    parameter int MUL_LAT    = MUL_LAT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    rc_result_stage_if.slave bus
);
    localparam int CNT_W = 3;

    rc_res_state_e                state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DP_WIDTH-1:0]          res_q, res_d;
    logic [ALU_N_FLAG-1:0]        flag_q, flag_d;
    logic                         br_req_q, br_req_d;
    logic [RCS_NUM_CREG_LOG2-1:0] br_add_q, br_add_d;
    logic                         commit_q, commit_d;
    logic                         do_commit;
    logic                         stall;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        flag_d    = flag_q;
        br_req_d  = 1'b0;
        br_add_d  = '0;
        commit_d  = 1'b0;
        do_commit = 1'b0;
        stall     = 1'b0;

        if (bus.flush_i) begin
            state_d = EXEC;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                EXEC: begin
                    if (bus.valid_i) begin
                        if (bus.alu_stall_i) begin
                            stall   = 1'b1;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                            state_d = MUL_WAIT;
                        end else begin
                            do_commit = 1'b1;
                        end
                    end
                end
                MUL_WAIT: begin
                    // The final wait cycle releases the stall and retires with the live ALU outputs.
                    if (cnt_q != '0) begin
                        stall = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        do_commit = 1'b1;
                        state_d   = EXEC;
                    end
                end
                default: state_d = EXEC;
            endcase
        end

        if (do_commit) begin
            if (bus.out_we_i)  res_d  = bus.alu_res_i;
            if (bus.flag_we_i) flag_d = bus.alu_flag_i;
            br_req_d = bus.alu_br_req_i;
            br_add_d = bus.alu_br_req_i ? bus.alu_br_add_i : '0;
            commit_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= EXEC;
            cnt_q    <= '0;
            res_q    <= '0;
            flag_q   <= '0;
            br_req_q <= 1'b0;
            br_add_q <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            flag_q   <= flag_d;
            br_req_q <= br_req_d;
            br_add_q <= br_add_d;
            commit_q <= commit_d;
        end
    end

    rc_rf #(
        .NUM_REG (RF_NUM_REG),
        .WIDTH   (DP_WIDTH)
    ) u_rf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (do_commit & bus.rf_we_i),
        .wsel_i  (bus.rf_wsel_i),
        .wdata_i (bus.alu_res_i),
        .rdata_o (bus.rf_rdata_o)
    );

    assign bus.res_o    = res_q;
    assign bus.flag_o   = flag_q;
    assign bus.br_req_o = br_req_q;
    assign bus.br_add_o = br_add_q;
    assign bus.commit_o = commit_q;
    assign bus.stall_o  = stall;
endmodule
